// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// EX-stage datapath that sits behind the ALU-control decoder. Logic, add/sub
// and compare operations complete in one cycle. Shifts use an iterative
// shifter that moves at most SHIFT_STEP bits per cycle. Valid/ready handshakes
// on both sides let the hazard unit stall the pipeline while a shift is running.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation offered
//   in_ready   unit can accept an operation (IDLE, or HOLD with out_ready)
//   alu_ctl    4-bit ALU control code
//   op_a       rs1 value
//   op_b       rs2 value or immediate (shift amount is op_b[4:0])
//   out_valid  registered result available
//   out_ready  downstream accepts the result
//   result     operation result
//   zero       result == 0 (meaningful only while out_valid is high)
//   busy       iterative shift in progress
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [1:0] SH_LEFT  = 2'd0;
    localparam logic [1:0] SH_RLOG  = 2'd1;
    localparam logic [1:0] SH_RARI  = 2'd2;

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    logic [1:0]      state_reg,     state_next;
    logic [XLEN-1:0] result_reg,    result_next;
    logic            zero_reg,      zero_next;
    logic [XLEN-1:0] work_reg,      work_next;
    logic [4:0]      remaining_reg, remaining_next;
    logic [1:0]      kind_reg,      kind_next;

    logic            accept;
    logic            dec_is_shift;
    logic [1:0]      dec_kind;
    logic [XLEN-1:0] dec_value;
    logic [4:0]      shamt;
    logic [4:0]      step_k;
    logic [XLEN-1:0] shifted;

    assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == ST_HOLD);
    assign busy      = (state_reg == ST_SHIFT);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign shamt     = op_b[4:0];

    // Operation decode. For shift codes dec_value is op_a, which is exactly
    // the answer when the shift amount is zero (no SHIFT state needed then).
    always_comb begin
        dec_is_shift = 1'b0;
        dec_kind     = SH_LEFT;
        dec_value    = '0;
        case (alu_ctl)
            4'b0000: dec_value = op_a & op_b;
            4'b0001: dec_value = op_a | op_b;
            4'b1011: dec_value = op_a ^ op_b;
            4'b0010: dec_value = op_a + op_b;
            4'b0110: dec_value = op_a - op_b;
            4'b1111: dec_value = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b0111: dec_value = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'b0011, 4'b1000: begin
                dec_is_shift = 1'b1;
                dec_kind     = SH_LEFT;
                dec_value    = op_a;
            end
            4'b0100, 4'b1001: begin
                dec_is_shift = 1'b1;
                dec_kind     = SH_RLOG;
                dec_value    = op_a;
            end
            4'b0101, 4'b1010: begin
                dec_is_shift = 1'b1;
                dec_kind     = SH_RARI;
                dec_value    = op_a;
            end
            default: dec_value = '0;   // undefined codes: result 0, zero 1
        endcase
    end

    // Bits moved this cycle: min(remaining, SHIFT_STEP).
    always_comb begin
        if ({1'b0, remaining_reg} > STEP) begin
            step_k = STEP[4:0];
        end else begin
            step_k = remaining_reg;
        end
    end

    // The working value starts as the captured op_a, so its MSB is the
    // captured sign bit for every SRA step.
    always_comb begin
        case (kind_reg)
            SH_LEFT: shifted = work_reg << step_k;
            SH_RLOG: shifted = work_reg >> step_k;
            default: shifted = $signed(work_reg) >>> step_k;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        result_next    = result_reg;
        zero_next      = zero_reg;
        work_next      = work_reg;
        remaining_next = remaining_reg;
        kind_next      = kind_reg;

        case (state_reg)
            ST_SHIFT: begin
                work_next      = shifted;
                remaining_next = remaining_reg - step_k;
                if (remaining_reg == step_k) begin
                    result_next = shifted;
                    zero_next   = (shifted == '0);
                    state_next  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: ;
        endcase

        // A new accept (from IDLE, or handoff from HOLD) overrides the above.
        if (accept) begin
            if (dec_is_shift && (shamt != 5'd0)) begin
                state_next     = ST_SHIFT;
                work_next      = op_a;
                remaining_next = shamt;
                kind_next      = dec_kind;
            end else begin
                state_next  = ST_HOLD;
                result_next = dec_value;
                zero_next   = (dec_value == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            work_reg      <= '0;
            remaining_reg <= '0;
            kind_reg      <= SH_LEFT;
        end else begin
            state_reg     <= state_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            work_reg      <= work_next;
            remaining_reg <= remaining_next;
            kind_reg      <= kind_next;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps
module tb_alu_exec_unit;

    localparam int W    = 32;
    localparam int STEP = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   alu_ctl = 4'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;

    alu_exec_unit #(.XLEN(W), .SHIFT_STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        int           cyc;   // cycle count at which out_valid must first be seen
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   popped = 0;
    int   last_wait = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: whole-operation arithmetic, shift applied in one go.
    function automatic logic [W-1:0] ref_res(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        int sh;
        logic signed [W-1:0] sa;
        sh = int'(b[4:0]);
        sa = a;
        case (c)
            4'd0:        return a & b;
            4'd1:        return a | b;
            4'd11:       return a ^ b;
            4'd2:        return a + b;
            4'd6:        return a - b;
            4'd15:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:        return (a < b) ? 32'd1 : 32'd0;
            4'd3, 4'd8:  return a << sh;
            4'd4, 4'd9:  return a >> sh;
            4'd5, 4'd10: return sa >>> sh;
            default:     return '0;
        endcase
    endfunction

    function automatic int ref_steps(input logic [3:0] c, input logic [W-1:0] b);
        int sh;
        sh = int'(b[4:0]);
        if (((c >= 4'd3 && c <= 4'd5) || (c >= 4'd8 && c <= 4'd10)) && sh > 0)
            return (sh + STEP - 1) / STEP;
        return 0;
    endfunction

    task automatic push_exp(input logic [W-1:0] r, input logic z, input int steps);
        exp_t e;
        e.res = r;
        e.z   = z;
        e.cyc = cyc + 1 + steps;
        sb_q.push_back(e);
    endtask

    // Monitor / scoreboard: compares whatever the DUT presents.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (out_valid && busy) check("valid_and_busy", 1, 0);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", result, 64'hDEAD);
                end else begin
                    if (!seen) begin
                        check("latency", cyc, sb_q[0].cyc);
                        check("result", result, sb_q[0].res);
                        check("zero", zero, sb_q[0].z);
                        seen = 1'b1;
                    end else begin
                        check("hold_stable", result, sb_q[0].res);
                    end
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        popped++;
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Offer one operation with literal expectations; returns one cycle after accept.
    task automatic offer(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e_res, input logic e_z, input int e_steps);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        alu_ctl  = c;
        op_a     = a;
        op_b     = b;
        while (n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        last_wait = n;
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end else begin
            push_exp(e_res, e_z, e_steps);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctl  = 4'($urandom_range(0, 15));
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        int base;
        int pushed;
        bit drop;
        logic [3:0] rc;
        logic [W-1:0] ra, rb, rr;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Basic ops, compares, undefined code, zero and short shifts
        out_ready = 1'b1;
        offer(4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 0);
        offer(4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 0);
        offer(4'b1111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 0);
        offer(4'b0111, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 0);
        offer(4'b1101, $urandom, $urandom, 32'd0, 1'b1, 0);
        offer(4'b0011, 32'd1, 32'd0, 32'd1, 1'b0, 0);
        offer(4'b1000, 32'd1, 32'h25, 32'h20, 1'b0, (5 + STEP - 1) / STEP);
        drain();

        // Long shifts
        offer(4'b0101, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, (31 + STEP - 1) / STEP);
        bcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        check("sra_busy_cycles", bcnt, (31 + STEP - 1) / STEP);
        @(posedge clk);
        #1;
        offer(4'b0100, 32'h80000000, 32'd31, 32'h00000001, 1'b0, (31 + STEP - 1) / STEP);
        drain();

        // Backpressure and same-cycle handoff
        out_ready = 1'b0;
        offer(4'b1011, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0, 0);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, 32'h0F0FF0F0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        offer(4'b0000, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0, 0);
        check("handoff_wait", last_wait, 0);
        drain();

        // Reset during a shift discards the operation
        offer(4'b0101, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, (31 + STEP - 1) / STEP);
        @(negedge clk);
        check("pre_reset_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Random regression with random backpressure
        base   = popped;
        pushed = 0;
        drop   = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (drop) begin
                in_valid = 1'b0;
                drop = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                rc = 4'($urandom_range(0, 15));
                ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : W'($urandom);
                rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
                in_valid = 1'b1;
                alu_ctl  = rc;
                op_a     = ra;
                op_b     = rb;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                rr = ref_res(alu_ctl, op_a, op_b);
                push_exp(rr, (rr == '0), ref_steps(alu_ctl, op_b));
                pushed++;
                drop = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check("random_result_count", popped - base, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- EX-stage datapath directly downstream of the ALU-control decoder. It consumes the 4-bit ALU control code plus two operands and produces a registered result and zero flag.
- Logic, arithmetic and compare ops complete in one cycle.
- Shifts run on an iterative shifter of SHIFT_STEP bits per cycle, so they take multiple cycles.
- A valid/ready handshake on both sides lets the hazard unit stall the pipeline while a shift is in flight.

Parameters:
- XLEN, 32, operand/result width.
- SHIFT_STEP, 8, maximum bits shifted per cycle in the SHIFT state; legal values are 1, 2, 4, 8, 16, 32.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept an operation.
- alu_ctl  input  4  control code from the ALU-control decoder.
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value or immediate.
- out_valid  output  1  result available.
- out_ready  input  1  downstream (EX/MEM) accepts the result.
- result  output  XLEN  operation result.
- zero  output  1  high when result == 0.
- busy  output  1  high in the SHIFT state; goes to the hazard unit.

Behaviour:
- Code map:
  - 0000 AND, 0001 OR, 1011 XOR.
  - 0010 ADD, 0110 SUB (modulo 2^XLEN).
  - 1111 SLT (signed), 0111 SLTU (unsigned); result is 0 or 1, zero-extended.
  - 0011/1000 SLL, 0100/1001 SRL, 0101/1010 SRA.
  - 1100, 1101, 1110 are undefined: result is 0, zero = 1, latency is 1 cycle.
- Shift amount is op_b[4:0]; op_b[XLEN-1:5] is ignored.
- States:
  - IDLE: no operation pending.
  - SHIFT: iterative shift in progress.
  - HOLD: result waiting for out_ready.
- Reset (asynchronous, any state, including mid-shift):
  - State goes to IDLE.
  - result = 0, zero = 0, out_valid = 0, busy = 0.
  - The in-flight operation is discarded.
- in_ready = (state == IDLE) || (state == HOLD && out_ready). A result and a new issue can therefore hand off in the same cycle.
- Accept occurs on in_valid && in_ready at edge T. Operands and alu_ctl are captured on that edge; later input changes are ignored.
- Non-shift, and shifts with shamt == 0:
  - result and zero are registered at edge T; out_valid is high from T+1.
  - State goes to HOLD.
- Shift with shamt > 0:
  - State goes to SHIFT, busy = 1, remaining = shamt.
  - Each cycle, shift the working value by k = min(remaining, SHIFT_STEP) and set remaining -= k.
  - SRA fills with the captured op_a[XLEN-1]; SLL and SRL fill with 0.
  - When remaining reaches 0, load result and zero and go to HOLD.
  - out_valid rises at cycle T+1+ceil(shamt/SHIFT_STEP).
  - Example: SHIFT_STEP = 8, shamt = 31 gives 4 SHIFT cycles; out_valid first seen at T+5.
- HOLD:
  - out_valid = 1; result and zero stay stable until out_ready.
  - On out_ready with no new accept, go to IDLE and clear out_valid on the same edge.
  - On out_ready with a new accept, behave exactly as an accept from IDLE.
- out_valid is never high in the SHIFT state.
- zero is valid only while out_valid is high.
- No combinational path from in_valid, operands or alu_ctl to any output. in_ready depends combinationally on out_ready only.
- Back-to-back single-cycle ops with out_ready held high give one result per cycle.

Test Plan:
- Reset/basic ops:
  - Assert rst_n = 0 mid-SHIFT, then release: out_valid = 0, busy = 0, in_ready = 1 on the next cycle.
  - ADD 0x7FFFFFFF + 1 gives 0x80000000 at T+1.
  - SUB 5-5 gives result 0, zero = 1.
- Compares: SLT with 0xFFFFFFFF vs 1 gives 1; SLTU with the same operands gives 0; both at 1-cycle latency.
- Shifts (SHIFT_STEP = 8):
  - SRA 0x80000000 by 31 gives 0xFFFFFFFF, out_valid at T+5, busy high for 4 cycles.
  - SRL of the same operands gives 0x00000001.
  - SLL 1 by 0 gives 1 at T+1.
  - SLLI 1 with op_b = 0x25 (shamt 5) gives 0x20.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles after XOR 0xF0F0F0F0 ^ 0xFFFF0000: result 0x0F0FF0F0 is held stable, in_ready = 0.
  - Raise out_ready together with a new AND: handoff in the same cycle, next result the following cycle.
- Undefined code: alu_ctl = 1101 with any operands gives result 0, zero = 1, 1-cycle latency.
- Random regression: 10k random alu_ctl/operands against a reference model with random out_ready. Check no dropped or duplicated results, and latency matches the formula for SHIFT_STEP = 1, 8 and 32.
